alu_cmd_driver: RTL and testbench

- Initiator side of the ALU operation interface.
- Accepts operation requests (A, B, OP) on a valid/ready command port and buffers them in a small FIFO.
- Issues one operation at a time to the ALU as a single-cycle en pulse, waits for done, captures the 16-bit result and returns it on a valid/ready response port.
- Sits between the test/stimulus or control logic and the ALU instance. The ALU's active-low rst_n is driven from ~rst at integration.

---
 rtl/alu_cmd_driver.sv | 168 ++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// Initiator for the ALU operation interface: queues commands in a small FIFO and
// issues them one at a time to the ALU, returning each result on a valid/ready port.
module alu_cmd_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic [2:0]  cmd_op,
    output logic        alu_en,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic        alu_done,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] b;
        logic [7:0] a;
    } cmd_t;

    cmd_t          mem_q [DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          push, pop, legal;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d, timer_inc;
    logic [7:0]    a_q, a_d, b_q, b_d;
    logic [2:0]    aop_q, aop_d, op_q, op_d;
    logic [15:0]   res_q, res_d;
    logic          err_q, err_d;

    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && (count_q != '0);
    assign head      = mem_q[rd_ptr_q];
    assign legal     = head.op <= 3'd5;
    assign timer_inc = timer_q + TW'(1);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + (AW+1)'(1);
        else if (pop && !push)
            count_d = count_q - (AW+1)'(1);
    end

    // Storage is not reset; only the pointers and count define the contents.
    always_ff @(posedge CLK) begin
        if (push)
            mem_q[wr_ptr_q] <= {cmd_op, cmd_b, cmd_a};
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            timer_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aop_q    <= '0;
            op_q     <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            state_q <= state_d;
            timer_q <= timer_d;
            a_q     <= a_d;
            b_q     <= b_d;
            aop_q   <= aop_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Done is checked before the timeout, so a late done on the last cycle still wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop) state_d = legal ? ISSUE : RESP;
            ISSUE:   state_d = WAIT;
            WAIT:    if (alu_done || timer_inc == TMAX) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        a_d     = a_q;
        b_d     = b_q;
        aop_d   = aop_q;
        op_d    = op_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    op_d = head.op;
                    // Illegal opcodes never reach the ALU, so its operands keep their last values.
                    if (legal) begin
                        a_d   = head.a;
                        b_d   = head.b;
                        aop_d = head.op;
                    end else begin
                        res_d = '0;
                        err_d = 1'b1;
                    end
                end
            end
            ISSUE: timer_d = '0;
            WAIT: begin
                if (alu_done) begin
                    res_d = alu_result;
                    err_d = 1'b0;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TMAX) begin
                        res_d = '0;
                        err_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cmd_ready  = !rst && (count_q < FULL_CNT);
        alu_en     = (state_q == ISSUE);
        alu_a      = a_q;
        alu_b      = b_q;
        alu_op     = aop_q;
        rsp_valid  = (state_q == RESP);
        rsp_result = res_q;
        rsp_op     = op_q;
        rsp_err    = err_q;
        busy       = (state_q != IDLE) || (count_q != '0);
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural ALU that answers one cycle after en.
module tb_alu_cmd_driver;
    logic        CLK = 1'b0;
    logic        rst, cmd_valid, cmd_ready, alu_en, alu_done = 1'b0;
    logic [7:0]  cmd_a, cmd_b, alu_a, alu_b;
    logic [2:0]  cmd_op, alu_op, rsp_op;
    logic [15:0] alu_result = '0, rsp_result;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic        kill_done = 1'b0;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, en_cnt = 0, run = 0, maxrun = 0, en_cyc_last = 0, rsp_n = 0;
    logic [19:0] rsp_log [64];
    int          rsp_cyc [64];
    int          rsp_encyc [64];

    always #5 CLK = ~CLK;

    alu_cmd_driver #(.DEPTH(4), .TIMEOUT(16)) dut (
        .CLK(CLK), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_done(alu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_op(rsp_op), .rsp_err(rsp_err), .busy(busy)
    );

    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return {8'h0, a} + {8'h0, b};
            3'd1:    return {8'h0, a} * {8'h0, b};
            3'd2:    return {8'h0, a & b};
            3'd3:    return {8'h0, a | b};
            3'd4:    return {8'h0, a ^ b};
            3'd5:    return {8'h0, ~a};
            default: return 16'hDEAD;
        endcase
    endfunction

    // Zero-wait ALU; kill_done models an ALU that never answers.
    always @(posedge CLK) begin
        alu_done <= 1'b0;
        if (alu_en && !kill_done) begin
            alu_done   <= 1'b1;
            alu_result <= alu_fn(alu_a, alu_b, alu_op);
        end
    end

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (alu_en) begin
            en_cnt      <= en_cnt + 1;
            en_cyc_last <= cyc;
            run         <= run + 1;
            if (run + 1 > maxrun) maxrun <= run + 1;
        end else begin
            run <= 0;
        end
        if (rsp_valid && rsp_ready) begin
            rsp_log[rsp_n]   <= {rsp_err, rsp_op, rsp_result};
            rsp_cyc[rsp_n]   <= cyc;
            rsp_encyc[rsp_n] <= en_cyc_last;
            rsp_n            <= rsp_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input string tag);
        int k = 0;
        while (rsp_n < target && k < 200) begin
            step();
            k++;
        end
        chk(tag, rsp_n, target);
    endtask

    task automatic chk_rsp(input string tag, input int idx, input logic err, input logic [2:0] op, input logic [15:0] res);
        logic [19:0] e;
        e = rsp_log[idx];
        chk({tag, "_err"}, e[19], err);
        chk({tag, "_op"}, e[18:16], op);
        chk({tag, "_res"}, e[15:0], res);
    endtask

    initial begin
        int base, e0, acc;
        logic rdy;
        logic [15:0] exp5 [5];
        exp5 = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};

        rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
        step(); step();
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_alu_en", alu_en, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0; rsp_ready = 1'b1;
        #1;
        chk("post_rst_cmd_ready", cmd_ready, 1);

        // Single ADD with the latency walked edge by edge
        e0 = en_cnt;
        cmd_valid = 1'b1; cmd_a = 8'd200; cmd_b = 8'd100; cmd_op = 3'd0;
        step();
        cmd_valid = 1'b0;
        chk("add_queued_busy", busy, 1);
        chk("add_queued_rsp_valid", rsp_valid, 0);
        step();
        chk("add_issue_en", alu_en, 1);
        chk("add_issue_a", alu_a, 200);
        chk("add_issue_b", alu_b, 100);
        chk("add_issue_op", alu_op, 0);
        step();
        chk("add_wait_en", alu_en, 0);
        chk("add_wait_rsp_valid", rsp_valid, 0);
        step();
        chk("add_rsp_valid", rsp_valid, 1);
        chk("add_rsp_result", rsp_result, 16'h012C);
        chk("add_rsp_op", rsp_op, 0);
        chk("add_rsp_err", rsp_err, 0);
        step();
        chk("add_done_rsp_valid", rsp_valid, 0);
        chk("add_done_busy", busy, 0);
        chk("add_en_pulses", en_cnt - e0, 1);

        // Back-to-back MUL, NOTA, XOR
        base = rsp_n; e0 = en_cnt;
        push_cmd(8'hFF, 8'hFF, 3'd1);
        push_cmd(8'h0F, 8'h00, 3'd5);
        push_cmd(8'hAA, 8'h55, 3'd4);
        wait_rsp(base + 3, "b2b_count");
        chk_rsp("b2b_mul", base, 1'b0, 3'd1, 16'hFE01);
        chk_rsp("b2b_nota", base + 1, 1'b0, 3'd5, 16'h00F0);
        chk_rsp("b2b_xor", base + 2, 1'b0, 3'd4, 16'h00FF);
        chk("b2b_en_pulses", en_cnt - e0, 3);
        chk("b2b_en_width", maxrun, 1);
        chk("b2b_spacing", rsp_cyc[base + 1] - rsp_cyc[base], 4);

        // Illegal opcode: error response, ALU untouched
        base = rsp_n; e0 = en_cnt;
        push_cmd(8'd1, 8'd2, 3'd6);
        wait_rsp(base + 1, "ill_count");
        chk_rsp("ill", base, 1'b1, 3'd6, 16'h0000);
        chk("ill_en_pulses", en_cnt - e0, 0);

        // Timeout, then the queued AND completes normally
        base = rsp_n;
        kill_done = 1'b1;
        push_cmd(8'd5, 8'd6, 3'd0);
        push_cmd(8'hF0, 8'h3C, 3'd2);
        wait_rsp(base + 1, "to_count");
        kill_done = 1'b0;
        chk_rsp("to", base, 1'b1, 3'd0, 16'h0000);
        chk("to_latency", rsp_cyc[base] - rsp_encyc[base], 16);
        wait_rsp(base + 2, "to_next_count");
        chk_rsp("to_next", base + 1, 1'b0, 3'd2, 16'h0030);

        // Backpressure: fill, hold the response, then drain
        base = rsp_n; rsp_ready = 1'b0; acc = 0;
        for (int i = 0; i < 12; i++) begin
            cmd_valid = 1'b1;
            cmd_a     = 8'((acc + 1) * 16);
            cmd_b     = 8'(acc + 1);
            cmd_op    = 3'd0;
            rdy       = cmd_ready;
            step();
            if (rdy) acc++;
        end
        cmd_valid = 1'b0;
        chk("bp_accepted", acc, 5);
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_hold_valid", rsp_valid, 1);
        chk("bp_hold_result", rsp_result, 16'h0011);
        step(); step(); step();
        chk("bp_hold_valid2", rsp_valid, 1);
        chk("bp_hold_result2", rsp_result, 16'h0011);
        chk("bp_hold_err2", rsp_err, 0);
        rsp_ready = 1'b1;
        wait_rsp(base + 5, "bp_count");
        for (int i = 0; i < 5; i++)
            chk_rsp($sformatf("bp_%0d", i), base + i, 1'b0, 3'd0, exp5[i]);
        chk("bp_idle_busy", busy, 0);

        // Reset while waiting on the ALU with three commands queued
        kill_done = 1'b1;
        base = rsp_n;
        push_cmd(8'h11, 8'h22, 3'd0);
        push_cmd(8'h01, 8'h01, 3'd0);
        push_cmd(8'h02, 8'h02, 3'd0);
        push_cmd(8'h03, 8'h03, 3'd0);
        chk("mr_wait_busy", busy, 1);
        chk("mr_wait_a", alu_a, 8'h11);
        rst = 1'b1;
        step();
        chk("mr_alu_en", alu_en, 0);
        chk("mr_alu_a", alu_a, 0);
        chk("mr_alu_b", alu_b, 0);
        chk("mr_alu_op", alu_op, 0);
        chk("mr_rsp_valid", rsp_valid, 0);
        chk("mr_rsp_result", rsp_result, 0);
        chk("mr_rsp_op", rsp_op, 0);
        chk("mr_rsp_err", rsp_err, 0);
        chk("mr_busy", busy, 0);
        chk("mr_cmd_ready", cmd_ready, 0);
        rst = 1'b0; kill_done = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("mr_no_rsp", rsp_n, base);
        chk("mr_idle_busy", busy, 0);
        push_cmd(8'h0F, 8'h30, 3'd3);
        wait_rsp(base + 1, "mr_post_count");
        chk_rsp("mr_post", base, 1'b0, 3'd3, 16'h003F);
        chk("final_en_width", maxrun, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
